// File: rtl/gpio_irq_pkg.sv
`default_nettype none
// ============================================================
// Module : gpio_irq_pkg
// Desc   : Shared constants and helpers for the gpio_irq block.
// Rev    : 1.0
// ============================================================
package gpio_irq_pkg;

    localparam int unsigned PIN_MAX = 32;
    localparam int unsigned DBNC_W  = 16;

    localparam logic [2:0] REG_LEVEL   = 3'd0;
    localparam logic [2:0] REG_ENABLE  = 3'd1;
    localparam logic [2:0] REG_RISE    = 3'd2;
    localparam logic [2:0] REG_BOTH    = 3'd3;
    localparam logic [2:0] REG_PENDING = 3'd4;
    localparam logic [2:0] REG_DBNC    = 3'd5;

    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_irq_sync.sv
`default_nettype none
// ============================================================
// Module : gpio_irq_sync
// Desc   : Per-pin two-flop synchroniser with optional tick-sampled
//          debounce filter (GPIO_IRQ_DEBOUNCE_EN).
// Rev    : 1.0
// ============================================================
module gpio_irq_sync
    import gpio_irq_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic pin_i,
    output logic cur_o
);

    logic sync1_q, sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    logic samp_q, filt_q;

    // Output only moves when two consecutive tick samples agree.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            samp_q <= 1'b0;
            filt_q <= 1'b0;
        end else if (tick_i) begin
            samp_q <= sync2_q;
            if (sync2_q == samp_q) begin
                filt_q <= sync2_q;
            end
        end
    end

    assign cur_o = filt_q;
`else
    logic w_unused_tick;
    assign w_unused_tick = tick_i;
    assign cur_o         = sync2_q;
`endif

endmodule
`default_nettype wire

// File: rtl/gpio_irq.sv
`default_nettype none
// ============================================================
// Module : gpio_irq
// Desc   : GPIO edge-interrupt front-end with Wishbone registers.
//          Optional debounce prescaler/filter: GPIO_IRQ_DEBOUNCE_EN.
// Rev    : 1.0
// ============================================================
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int unsigned PIN_NUM = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cyc_i,
    input  logic               stb_i,
    input  logic [31:0]        adr_i,
    input  logic               we_i,
    input  logic [3:0]         sel_i,
    input  logic [31:0]        dat_i,
    output logic [31:0]        dat_o,
    output logic               ack_o,
    input  logic [PIN_NUM-1:0] pin_i,
    output logic               irq_o
);

    logic               w_cs, w_wr, w_tick;
    logic [31:0]        w_bmask, w_rd;
    logic [PIN_NUM-1:0] w_m, w_wd, w_cur, w_rise, w_fall, w_hit, w_clr;
    logic [DBNC_W-1:0]  w_dbnc_rd;
    logic               w_unused_bits;

    logic               ack_q, ack_d, irq_q, irq_d;
    logic [PIN_NUM-1:0] enable_q, enable_d, rise_q, rise_d, both_q, both_d;
    logic [PIN_NUM-1:0] pending_q, pending_d, prev_q;

    assign w_cs    = cyc_i & stb_i;
    assign w_wr    = w_cs & we_i & ~ack_q;
    assign w_bmask = sel_to_mask(sel_i);
    assign w_m     = w_bmask[PIN_NUM-1:0];
    assign w_wd    = dat_i[PIN_NUM-1:0];
    assign w_unused_bits = ^{adr_i, dat_i, w_bmask};

`ifdef GPIO_IRQ_DEBOUNCE_EN
    logic [DBNC_W-1:0] dbnc_q, dbnc_d, cnt_q, cnt_d;

    assign w_tick    = (cnt_q == dbnc_q);
    assign w_dbnc_rd = dbnc_q;

    always_comb begin
        dbnc_d = dbnc_q;
        cnt_d  = w_tick ? '0 : cnt_q + DBNC_W'(1);
        if (w_wr && (adr_i[4:2] == REG_DBNC)) begin
            dbnc_d = (dbnc_q & ~w_bmask[DBNC_W-1:0]) | (dat_i[DBNC_W-1:0] & w_bmask[DBNC_W-1:0]);
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dbnc_q <= '0;
            cnt_q  <= '0;
        end else begin
            dbnc_q <= dbnc_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    assign w_tick    = 1'b1;
    assign w_dbnc_rd = '0;
`endif

    for (genvar i = 0; i < PIN_NUM; i++) begin : g_pin
        gpio_irq_sync u_sync (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .tick_i (w_tick),
            .pin_i  (pin_i[i]),
            .cur_o  (w_cur[i])
        );
    end

    assign w_rise = w_cur & ~prev_q;
    assign w_fall = ~w_cur & prev_q;
    assign w_hit  = (both_q & (w_rise | w_fall))
                  | (~both_q & rise_q & w_rise)
                  | (~both_q & ~rise_q & w_fall);

    // Hit is OR-ed after the clear so a coincident set wins.
    always_comb begin
        enable_d = enable_q;
        rise_d   = rise_q;
        both_d   = both_q;
        w_clr    = '0;
        if (w_wr) begin
            case (adr_i[4:2])
                REG_ENABLE:  enable_d = (enable_q & ~w_m) | (w_wd & w_m);
                REG_RISE:    rise_d   = (rise_q & ~w_m) | (w_wd & w_m);
                REG_BOTH:    both_d   = (both_q & ~w_m) | (w_wd & w_m);
                REG_PENDING: w_clr    = w_wd & w_m;
                default: ;
            endcase
        end
        pending_d = (pending_q & ~w_clr) | w_hit;
        ack_d     = w_cs & ~ack_q;
        irq_d     = |(pending_q & enable_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q     <= 1'b0;
            irq_q     <= 1'b0;
            enable_q  <= '0;
            rise_q    <= '0;
            both_q    <= '0;
            pending_q <= '0;
            prev_q    <= '0;
        end else begin
            ack_q     <= ack_d;
            irq_q     <= irq_d;
            enable_q  <= enable_d;
            rise_q    <= rise_d;
            both_q    <= both_d;
            pending_q <= pending_d;
            prev_q    <= w_cur;
        end
    end

    always_comb begin
        w_rd = '0;
        case (adr_i[4:2])
            REG_LEVEL:   w_rd[PIN_NUM-1:0] = w_cur;
            REG_ENABLE:  w_rd[PIN_NUM-1:0] = enable_q;
            REG_RISE:    w_rd[PIN_NUM-1:0] = rise_q;
            REG_BOTH:    w_rd[PIN_NUM-1:0] = both_q;
            REG_PENDING: w_rd[PIN_NUM-1:0] = pending_q;
            REG_DBNC:    w_rd[DBNC_W-1:0]  = w_dbnc_rd;
            default: ;
        endcase
    end

    assign dat_o = w_rd;
    assign ack_o = ack_q;
    assign irq_o = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_irq.sv
`default_nettype none
// ============================================================
// Module : tb_gpio_irq
// Desc   : Randomised + directed bench for gpio_irq against a
//          pin-history reference model.
// Rev    : 1.0
// ============================================================
module tb_gpio_irq;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0]  adr = '0, dat_w = '0, dat_r;
    logic [3:0]   sel = '0;
    logic         ack, irq;
    logic [N-1:0] pin = '0;

    always #5 clk = ~clk;

    gpio_irq #(.PIN_NUM(N)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .cyc_i  (cyc),
        .stb_i  (stb),
        .adr_i  (adr),
        .we_i   (we),
        .sel_i  (sel),
        .dat_i  (dat_w),
        .dat_o  (dat_r),
        .ack_o  (ack),
        .pin_i  (pin),
        .irq_o  (irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: register contents plus history of pin levels seen at each edge
    logic [N-1:0] m_en, m_rise, m_both, m_pend, m_samp;
    logic [15:0]  m_dbnc, m_cnt;
    logic         m_ack, m_irq;
    logic [N-1:0] hist[$];
    logic [N-1:0] curh[$];

    task automatic model_reset();
        m_en = '0; m_rise = '0; m_both = '0; m_pend = '0; m_samp = '0;
        m_dbnc = '0; m_cnt = '0; m_ack = 1'b0; m_irq = 1'b0;
        hist = {};
        repeat (3) hist.push_back('0);
        curh = {};
        repeat (2) curh.push_back('0);
    endtask

    function automatic logic [N-1:0] merge(input logic [N-1:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [N-1:0] r = old;
        for (int b = 0; b < N; b++) if (s[b/8]) r[b] = d[b];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        logic [31:0] r = '0;
        case (a)
            3'd0: r[N-1:0] = curh[$];
            3'd1: r[N-1:0] = m_en;
            3'd2: r[N-1:0] = m_rise;
            3'd3: r[N-1:0] = m_both;
            3'd4: r[N-1:0] = m_pend;
`ifdef GPIO_IRQ_DEBOUNCE_EN
            3'd5: r[15:0] = m_dbnc;
`endif
            default: ;
        endcase
        return r;
    endfunction

    // One clock edge: advance model with the inputs present before it, then compare.
    task automatic step();
        logic         cs, wr;
        logic [N-1:0] c, pv, hit, cur_new, clr;
        logic [N-1:0] s, agree;
        logic         irq_new;
        cs = cyc & stb;
        wr = cs & we & ~m_ack;
        @(posedge clk);
        hist.push_back(pin);
        if (hist.size() > 4) void'(hist.pop_front());
`ifdef GPIO_IRQ_DEBOUNCE_EN
        cur_new = curh[$];
        if (m_cnt == m_dbnc) begin
            s = hist[$-2];
            agree = ~(s ^ m_samp);
            cur_new = (cur_new & ~agree) | (s & agree);
            m_samp = s;
            m_cnt = '0;
        end else begin
            m_cnt = m_cnt + 16'd1;
        end
`else
        s = '0; agree = '0;
        cur_new = hist[$-1];
`endif
        c  = curh[$];
        pv = curh[$-1];
        for (int i = 0; i < N; i++) begin
            if (m_both[i])      hit[i] = (c[i] != pv[i]);
            else if (m_rise[i]) hit[i] = c[i] && !pv[i];
            else                hit[i] = !c[i] && pv[i];
        end
        irq_new = |(m_pend & m_en);
        clr = '0;
        if (wr) begin
            case (adr[4:2])
                3'd1: m_en   = merge(m_en, dat_w, sel);
                3'd2: m_rise = merge(m_rise, dat_w, sel);
                3'd3: m_both = merge(m_both, dat_w, sel);
                3'd4: clr    = merge('0, dat_w, sel);
`ifdef GPIO_IRQ_DEBOUNCE_EN
                3'd5: begin
                    for (int b = 0; b < 16; b++) if (sel[b/8]) m_dbnc[b] = dat_w[b];
                    m_cnt = '0;
                end
`endif
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clr) | hit;
        m_irq  = irq_new;
        m_ack  = cs & ~m_ack;
        curh.push_back(cur_new);
        void'(curh.pop_front());
        #1;
        check("ack", 32'(ack), 32'(m_ack));
        check("irq", 32'(irq), 32'(m_irq));
        check("dat", dat_r, exp_rd(adr[4:2]));
    endtask

    task automatic idle(input int n);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset(input bit check_drop);
        rst_n = 1'b0;
        #1;
        if (check_drop) begin
            check("rst_ack_drop", 32'(ack), 32'd0);
            check("rst_irq_drop", 32'(irq), 32'd0);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        int k = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {27'd0, a, 2'b00}; dat_w = d; sel = s;
        do begin step(); k++; end while (!ack && k < 4);
        check("wr_ack", 32'(ack), 32'd1);
        idle(1);
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] v);
        int k = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {27'd0, a, 2'b00}; sel = 4'hF;
        do begin step(); k++; end while (!ack && k < 4);
        check("rd_ack", 32'(ack), 32'd1);
        v = dat_r;
        idle(1);
    endtask

    task automatic peek(input logic [2:0] a, output logic [31:0] v);
        adr = {27'd0, a, 2'b00};
        #1;
        v = dat_r;
    endtask

    logic [31:0] v;

    initial begin
        do_reset(1'b0);

        // Reset state: every address reads zero
        for (int a = 0; a < 8; a++) begin
            wb_read(3'(a), v);
            check("rst_read", v, 32'd0);
        end
        check("rst_irq", 32'(irq), 32'd0);

        // Rising edge on pin 0: pending at edge 3, irq after edge 4, W1C drops irq
        wb_write(3'd1, 32'h1, 4'hF);
        wb_write(3'd2, 32'h1, 4'hF);
        pin[0] = 1'b1;
        step(); step();
        peek(3'd4, v); check("pend_e2", v, 32'h0);
        step();
        peek(3'd4, v); check("pend_e3", v, 32'h1);
        check("irq_e3", 32'(irq), 32'd0);
        step();
        check("irq_e4", 32'(irq), 32'd1);
        wb_write(3'd4, 32'h1, 4'hF);
        check("irq_w1c", 32'(irq), 32'd0);

        // Any-edge on pin 2, then falling-only on pin 1
        wb_write(3'd3, 32'h4, 4'hF);
        pin[2] = 1'b1; idle(4);
        peek(3'd4, v); check("both_rise", 32'(v[2]), 32'd1);
        wb_write(3'd4, 32'h4, 4'hF);
        pin[2] = 1'b0; idle(4);
        peek(3'd4, v); check("both_fall", 32'(v[2]), 32'd1);
        wb_write(3'd4, 32'h4, 4'hF);
        wb_write(3'd3, 32'h0, 4'hF);
        pin[1] = 1'b1; idle(4);
        peek(3'd4, v); check("fall_only_rise", 32'(v[1]), 32'd0);
        pin[1] = 1'b0; idle(4);
        peek(3'd4, v); check("fall_only_fall", 32'(v[1]), 32'd1);
        wb_write(3'd4, 32'h2, 4'hF);

        // Set wins over coincident W1C on pin 3
        wb_write(3'd3, 32'h8, 4'hF);
        pin[3] = 1'b1; idle(5);
        pin[3] = 1'b0; step(); step();
        wb_write(3'd4, 32'h8, 4'hF);
        peek(3'd4, v); check("set_wins", 32'(v[3]), 32'd1);
        wb_write(3'd4, 32'h8, 4'hF);

        // Masked pending, then enable raises irq next cycle
        wb_write(3'd1, 32'h0, 4'hF);
        wb_write(3'd2, 32'h20, 4'hF);
        pin[5] = 1'b1; idle(5);
        peek(3'd4, v); check("masked_pend", 32'(v[5]), 32'd1);
        check("masked_irq", 32'(irq), 32'd0);
        wb_write(3'd1, 32'h20, 4'hF);
        check("enable_irq", 32'(irq), 32'd1);

        // Reset in the middle of an access
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
        step();
        do_reset(1'b1);
        idle(4);
        wb_write(3'd4, 32'h3FF, 4'hF);

        // Three-cycle glitch on pin 4 with any-edge detection
        wb_write(3'd3, 32'h10, 4'hF);
        wb_write(3'd5, 32'h3, 4'hF);
        wb_write(3'd4, 32'h3FF, 4'hF);
        pin[4] = 1'b1; idle(3);
        pin[4] = 1'b0; idle(20);
        peek(3'd4, v);
`ifdef GPIO_IRQ_DEBOUNCE_EN
        check("glitch_filtered", 32'(v[4]), 32'd0);
        peek(3'd5, v); check("dbnc_rd", v, 32'h3);
`else
        check("glitch_seen", 32'(v[4]), 32'd1);
        peek(3'd5, v); check("dbnc_rd", v, 32'h0);
`endif
        wb_write(3'd4, 32'h10, 4'hF);
        pin[4] = 1'b1; idle(20);
        peek(3'd4, v); check("held_level", 32'(v[4]), 32'd1);

        // Random traffic on bus and pins
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                int idx = $urandom_range(0, N - 1);
                pin[idx] = ~pin[idx];
            end
            cyc   = ($urandom_range(0, 3) != 0);
            stb   = ($urandom_range(0, 2) == 0);
            we    = ($urandom_range(0, 1) == 1);
            adr   = $urandom;
            sel   = 4'($urandom_range(0, 15));
            dat_w = $urandom;
`ifdef GPIO_IRQ_DEBOUNCE_EN
            if (adr[4:2] == 3'd5) dat_w = 32'($urandom_range(0, 3));
`endif
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
